// File: rtl/cfs_algn_pkg.sv
// Shared types and width helpers for the MD responder and its packer.
package cfs_algn_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Bytes per MD word.
   function automatic int nb_f(input int dw);
      return dw / 8;
   endfunction

   // Byte-offset field width.
   function automatic int ow_f(input int dw);
      return $clog2(dw / 8);
   endfunction

   // Size field width: one more bit than offset so a full word fits.
   function automatic int sw_f(input int dw);
      return $clog2(dw / 8) + 1;
   endfunction

   // Saturating counter increment.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/cfs_md_packer.sv
// Byte packer: appends accepted MD bytes above the held partial word and
// emits full words through a single output register.
module cfs_md_packer
   import cfs_algn_pkg::*;
#(
   parameter  int DW = 32,
   localparam int NB = nb_f(DW),
   localparam int OW = ow_f(DW),
   localparam int SW = sw_f(DW)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic [OW-1:0] offset_i,
   input  logic [SW-1:0] size_i,
   input  logic          out_ready_i,
   output logic          stall_o,
   output logic          out_valid_o,
   output logic [DW-1:0] out_data_o
);

   logic [DW-1:0]   acc_q;
   logic [OW-1:0]   acc_cnt_q;
   logic            out_valid_q;
   logic [DW-1:0]   out_data_q;

   logic [DW-1:0]   shifted;
   logic [DW-1:0]   ext;
   logic [2*DW-1:0] comb;
   logic [SW:0]     total;
   logic            wrap;

   // Extra bit keeps acc_cnt + size from wrapping even for oversized requests.
   assign total = (SW+1)'(acc_cnt_q) + (SW+1)'(size_i);
   assign wrap  = total >= (SW+1)'(NB);

   // A push that completes a word cannot proceed while the old word is stuck.
   assign stall_o = out_valid_q && !out_ready_i && wrap;

   // Extract the valid request bytes and lay them above the held bytes.
   always_comb begin
      shifted = data_i >> {offset_i, 3'b000};
      ext     = '0;
      for (int b = 0; b < NB; b++) begin
         if (SW'(b) < size_i) ext[8*b +: 8] = shifted[8*b +: 8];
      end
      comb = {{DW{1'b0}}, acc_q} | ({{DW{1'b0}}, ext} << {acc_cnt_q, 3'b000});
   end

   // Accumulator and output register; consume and reload may share a cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         acc_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
         if (push_i) begin
            if (wrap) begin
               out_data_q  <= comb[DW-1:0];
               out_valid_q <= 1'b1;
               acc_q       <= comb[2*DW-1:DW];
               acc_cnt_q   <= OW'(total - (SW+1)'(NB));
            end else begin
               acc_q       <= comb[DW-1:0];
               acc_cnt_q   <= OW'(total);
            end
         end
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;

endmodule

// File: rtl/cfs_md_responder.sv
// MD responder: handshake FSM with programmable wait states, legality check,
// transfer/error counters, and a byte packer feeding an output word stream.
module cfs_md_responder
   import cfs_algn_pkg::*;
#(
   parameter  int ALGN_DATA_WIDTH = 32,
   localparam int NB = nb_f(ALGN_DATA_WIDTH),
   localparam int OW = ow_f(ALGN_DATA_WIDTH),
   localparam int SW = sw_f(ALGN_DATA_WIDTH)
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       md_valid,
   input  logic [ALGN_DATA_WIDTH-1:0] md_data,
   input  logic [OW-1:0]              md_offset,
   input  logic [SW-1:0]              md_size,
   output logic                       md_ready,
   output logic                       md_err,
   input  logic [3:0]                 cfg_wait,
   output logic                       out_valid,
   output logic [ALGN_DATA_WIDTH-1:0] out_data,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           xfer_cnt,
   output logic [CNT_W-1:0]           err_cnt
);

   state_e           state_q;
   logic [3:0]       wait_q;
   logic             md_ready_q;
   logic             md_err_q;
   logic [CNT_W-1:0] xfer_q;
   logic [CNT_W-1:0] err_q;

   logic legal;
   logic stall;
   logic accept;
   logic push;

   assign legal  = (md_size != '0) &&
                   ((SW+1)'(md_offset) + (SW+1)'(md_size) <= (SW+1)'(NB));
   // Illegal transfers never touch the packer, so they never stall.
   assign accept = !legal || !stall;
   // The transfer is committed in the last WAIT cycle; md_ready follows.
   assign push   = (state_q == ST_WAIT) && md_valid && (wait_q == '0) && accept && legal;

   // Handshake FSM with registered md_ready/md_err and saturating counters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         wait_q     <= '0;
         md_ready_q <= 1'b0;
         md_err_q   <= 1'b0;
         xfer_q     <= '0;
         err_q      <= '0;
      end else begin
         md_ready_q <= 1'b0;
         md_err_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (md_valid) begin
                  state_q <= ST_WAIT;
                  wait_q  <= cfg_wait;
               end
            end
            ST_WAIT: begin
               if (!md_valid) begin
                  state_q <= ST_IDLE;
               end else if (wait_q == '0 && accept) begin
                  state_q    <= ST_RESP;
                  md_ready_q <= 1'b1;
                  md_err_q   <= !legal;
                  xfer_q     <= sat_inc(xfer_q);
                  if (!legal) err_q <= sat_inc(err_q);
               end else if (wait_q != '0) begin
                  wait_q <= wait_q - 4'd1;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   cfs_md_packer #(.DW(ALGN_DATA_WIDTH)) u_packer (
      .clk         (clk),
      .reset_n     (reset_n),
      .push_i      (push),
      .data_i      (md_data),
      .offset_i    (md_offset),
      .size_i      (md_size),
      .out_ready_i (out_ready),
      .stall_o     (stall),
      .out_valid_o (out_valid),
      .out_data_o  (out_data)
   );

   assign md_ready = md_ready_q;
   assign md_err   = md_err_q;
   assign xfer_cnt = xfer_q;
   assign err_cnt  = err_q;

endmodule

// File: tb/tb_cfs_md_responder.sv
// Directed bench for cfs_md_responder with hand-computed expectations.
module tb_cfs_md_responder;

   logic        clk;
   logic        reset_n;
   logic        md_valid;
   logic [31:0] md_data;
   logic [1:0]  md_offset;
   logic [2:0]  md_size;
   logic        md_ready;
   logic        md_err;
   logic [3:0]  cfg_wait;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;
   logic [15:0] xfer_cnt;
   logic [15:0] err_cnt;

   int checks = 0;
   int passes = 0;
   int lat;
   int seen;

   cfs_md_responder #(.ALGN_DATA_WIDTH(32)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .md_valid  (md_valid),
      .md_data   (md_data),
      .md_offset (md_offset),
      .md_size   (md_size),
      .md_ready  (md_ready),
      .md_err    (md_err),
      .cfg_wait  (cfg_wait),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt),
      .err_cnt   (err_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present a request and count cycles until md_ready (bounded).
   task automatic req(input logic [3:0] w, input logic [1:0] off, input logic [2:0] sz,
                      input logic [31:0] d, output int l);
      cfg_wait  = w;
      md_offset = off;
      md_size   = sz;
      md_data   = d;
      md_valid  = 1'b1;
      l = 0;
      do begin
         tick();
         l++;
      end while (!md_ready && l < 40);
   endtask

   task automatic done();
      md_valid = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      md_valid = 1'b0;
      reset_n  = 1'b0;
      tick();
      reset_n  = 1'b1;
      tick();
   endtask

   initial begin
      reset_n = 1'b1; md_valid = 1'b0; md_data = '0; md_offset = '0; md_size = '0;
      cfg_wait = '0; out_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_ready",  32'(md_ready),  0);
      chk("rst_err",    32'(md_err),    0);
      chk("rst_oval",   32'(out_valid), 0);
      chk("rst_odata",  out_data,       0);
      chk("rst_xfer",   32'(xfer_cnt),  0);
      chk("rst_errcnt", 32'(err_cnt),   0);
      chk("rst_acc",    32'(dut.u_packer.acc_cnt_q), 0);
      tick(); tick();
      reset_n = 1'b1;

      // Full aligned word, no wait states.
      req(4'd0, 2'd0, 3'd4, 32'hDDCCBBAA, lat);
      chk("t1_lat",   lat, 2);
      chk("t1_err",   32'(md_err), 0);
      chk("t1_oval",  32'(out_valid), 1);
      chk("t1_odata", out_data, 32'hDDCCBBAA);
      chk("t1_xfer",  32'(xfer_cnt), 1);
      done();

      // Two half-words with 3 wait states assemble one word.
      req(4'd3, 2'd1, 3'd2, 32'h00BBAA00, lat);
      chk("t2a_lat",  lat, 5);
      chk("t2a_acc",  32'(dut.u_packer.acc_cnt_q), 2);
      chk("t2a_oval", 32'(out_valid), 0);
      done();
      req(4'd3, 2'd0, 3'd2, 32'h0000DDCC, lat);
      chk("t2b_lat",   lat, 5);
      chk("t2b_oval",  32'(out_valid), 1);
      chk("t2b_odata", out_data, 32'hDDCCBBAA);
      chk("t2b_acc",   32'(dut.u_packer.acc_cnt_q), 0);
      chk("t2b_xfer",  32'(xfer_cnt), 3);
      done();

      // Offset+size overflow is illegal and leaves the packer alone.
      do_reset();
      req(4'd0, 2'd0, 3'd1, 32'h000000AB, lat);
      done();
      req(4'd0, 2'd3, 3'd2, 32'hFFFFFFFF, lat);
      chk("t3_lat",    lat, 2);
      chk("t3_err",    32'(md_err), 1);
      chk("t3_errcnt", 32'(err_cnt), 1);
      chk("t3_acc",    32'(dut.u_packer.acc_cnt_q), 1);
      chk("t3_oval",   32'(out_valid), 0);
      done();

      // Zero size is illegal; a following full word is legal.
      do_reset();
      req(4'd0, 2'd0, 3'd0, 32'h12345678, lat);
      chk("t4a_err", 32'(md_err), 1);
      done();
      req(4'd0, 2'd0, 3'd4, 32'h44332211, lat);
      chk("t4b_err",    32'(md_err), 0);
      chk("t4b_xfer",   32'(xfer_cnt), 2);
      chk("t4b_errcnt", 32'(err_cnt), 1);
      chk("t4b_odata",  out_data, 32'h44332211);
      done();

      // Backpressure: full output, acc_cnt=3, size=2 must wait for out_ready.
      out_ready = 1'b0;
      req(4'd0, 2'd0, 3'd4, 32'h03020100, lat);
      done();
      req(4'd0, 2'd0, 3'd3, 32'h00060504, lat);
      chk("t5_pre_lat", lat, 2);
      chk("t5_pre_acc", 32'(dut.u_packer.acc_cnt_q), 3);
      done();
      cfg_wait = 4'd0; md_offset = 2'd0; md_size = 3'd2; md_data = 32'h00000807;
      md_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (md_ready) seen++;
      end
      chk("t5_stall_ready", seen, 0);
      chk("t5_stall_odata", out_data, 32'h03020100);
      chk("t5_stall_oval",  32'(out_valid), 1);
      out_ready = 1'b1;
      tick();
      chk("t5_rel_ready", 32'(md_ready), 1);
      chk("t5_rel_odata", out_data, 32'h07060504);
      chk("t5_rel_oval",  32'(out_valid), 1);
      chk("t5_rel_acc",   32'(dut.u_packer.acc_cnt_q), 1);
      done();
      req(4'd0, 2'd1, 3'd3, 32'h0B0A0900, lat);
      chk("t5_d_odata", out_data, 32'h0B0A0908);
      chk("t5_d_acc",   32'(dut.u_packer.acc_cnt_q), 0);
      done();

      // Reset in WAIT with 2 bytes held discards everything.
      req(4'd0, 2'd0, 3'd2, 32'h0000BBAA, lat);
      done();
      chk("t6_pre_acc", 32'(dut.u_packer.acc_cnt_q), 2);
      cfg_wait = 4'd5; md_offset = 2'd0; md_size = 3'd4; md_data = 32'h12345678;
      md_valid = 1'b1;
      tick(); tick();
      reset_n = 1'b0;
      #1;
      chk("t6_rst_ready",  32'(md_ready),  0);
      chk("t6_rst_odata",  out_data,       0);
      chk("t6_rst_oval",   32'(out_valid), 0);
      chk("t6_rst_xfer",   32'(xfer_cnt),  0);
      chk("t6_rst_errcnt", 32'(err_cnt),   0);
      chk("t6_rst_acc",    32'(dut.u_packer.acc_cnt_q), 0);
      md_valid = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      req(4'd0, 2'd0, 3'd4, 32'h55667788, lat);
      chk("t6_lat",   lat, 2);
      chk("t6_odata", out_data, 32'h55667788);
      chk("t6_acc",   32'(dut.u_packer.acc_cnt_q), 0);
      chk("t6_xfer",  32'(xfer_cnt), 1);
      done();

      // md_valid withdrawn during WAIT: no response, no side effects.
      cfg_wait = 4'd3; md_offset = 2'd0; md_size = 3'd2; md_data = 32'h00002211;
      md_valid = 1'b1;
      tick(); tick();
      md_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (md_ready) seen++;
      end
      chk("t7_ready", seen, 0);
      chk("t7_xfer",  32'(xfer_cnt), 1);
      chk("t7_acc",   32'(dut.u_packer.acc_cnt_q), 0);
      req(4'd0, 2'd0, 3'd4, 32'hCAFEF00D, lat);
      chk("t7_lat",   lat, 2);
      chk("t7_odata", out_data, 32'hCAFEF00D);
      done();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
